kill_search_engine: RTL and testbench
=====================================

KILL_SEARCH_ENGINE -- requirements
Module: kill_search_engine

Interface
REQ-001 SHALL have parameter MAX_DEPTH, default 9, number of search levels (level 0 = root attacker move).
REQ-002 SHALL have parameter MOVE_W, default 8, width of a cell index (0..224 legal).
REQ-003 SHALL have parameter NODE_BUDGET, default 4096, maximum oracle queries per search (used only under KILL_BUDGET_EN).
REQ-004 Ports, clock and reset first:
  i_clk  in  1  single clock, all logic rising-edge.
  i_rst  in  1  asynchronous, active-high reset.
  i_start  in  1  start search, sampled in IDLE only.
  i_abort  in  1  terminate running search.
  i_depth  in  5  runtime level limit; values >= MAX_DEPTH are clipped to MAX_DEPTH-1.
  i_side  in  2  attacker stone code.
  i_board  in  board  root position, captured on accepted i_start.
  o_q_valid  out  1  oracle query valid.
  i_q_ready  in  1  oracle accepts query.
  o_q_board  out  board  current working position.
  o_q_level  out  5  current level.
  o_q_after  out  MOVE_W  return first candidate with index > this; NO_MOVE = from start.
  i_r_valid  in  1  oracle response strobe.
  i_r_found  in  1  a candidate exists.
  i_r_move  in  MOVE_W  candidate cell.
  i_r_win  in  1  candidate wins immediately for the side to move.
  o_busy  out  1  search running.
  o_finish  out  1  one-cycle completion pulse.
  o_sha  out  1  forced win found for attacker.
  o_first_move  out  MOVE_W  winning root move, NO_MOVE when o_sha=0.
  o_timeout  out  1  search ended by budget.

Function
REQ-005 SHALL implement states IDLE, QUERY, WAIT, DESCEND, ASCEND, DONE.
REQ-006 Even levels SHALL be attacker (OR node: one successful child suffices); odd levels defender (AND node: all children must succeed).
REQ-007 IDLE->QUERY one cycle after i_start; board captured, level 0, after=NO_MOVE, o_busy high.
REQ-008 QUERY SHALL hold o_q_valid and all o_q_* stable until i_q_ready; then WAIT; one query outstanding at most.
REQ-009 i_r_valid outside WAIT SHALL be ignored.
REQ-010 i_r_move >= 225 or pointing at an occupied cell SHALL be treated as i_r_found=0.
REQ-011 found=0: attacker level fails, defender level succeeds; result passed to ASCEND.
REQ-012 found=1, win=1: attacker level succeeds; defender level fails.
REQ-013 found=1, win=0, level == depth limit: attacker level re-queries with after=i_r_move; defender level fails.
REQ-014 found=1, win=0, level < limit: DESCEND places stone (attacker code at even, opposite code at odd level), pushes move, level+1, after=NO_MOVE.
REQ-015 ASCEND with child result r SHALL remove the parent's pushed stone, pop, then: attacker r=1 succeed, r=0 re-query after popped move; defender r=0 fail, r=1 re-query.
REQ-016 Resolution at level 0 SHALL enter DONE: o_sha=result, o_first_move=deciding root move, o_finish pulsed exactly one cycle, o_busy low the same cycle; next cycle IDLE.
REQ-017 i_abort in any non-IDLE state SHALL go to DONE next cycle with o_sha=0, o_first_move=NO_MOVE; pending response discarded.
REQ-018 i_start while busy SHALL be ignored; i_start and i_abort together in IDLE: start wins.
REQ-019 o_sha, o_first_move, o_timeout SHALL hold until next accepted i_start.

Reset
REQ-020 i_rst SHALL asynchronously force IDLE, working board empty, stack empty, o_q_valid=0, o_busy=0, o_finish=0, o_sha=0, o_timeout=0, o_first_move=NO_MOVE, including mid-search.

Configuration
REQ-021 With KILL_BUDGET_EN defined, a query counter (reset on start) SHALL end the search at NODE_BUDGET accepted queries: DONE, o_sha=0, o_timeout=1.
REQ-022 Without KILL_BUDGET_EN, no counter SHALL exist and o_timeout SHALL be constant 0.

Structure
REQ-023 Package gobang_pkg SHALL hold the board typedef, cell codes (EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10), CELLS=225, NO_MOVE=8'hFF.
REQ-024 Move stack SHALL be sub-module kill_stack (MAX_DEPTH x MOVE_W LIFO, push/pop/top).

Verification
REQ-025 Oracle answers level 0 found=1 move=112 win=1 -> o_sha=1, o_first_move=112, one o_finish pulse.
REQ-026 Level 0 found=0 immediately -> o_sha=0, o_first_move=8'hFF.
REQ-027 i_depth=2, defender refutes root move 40, root move 41 wins at level 2 -> o_sha=1, o_first_move=41, board restored to root after finish.
REQ-028 i_q_ready low 5 cycles -> o_q_* stable throughout; stray i_r_valid in QUERY ignored.
REQ-029 i_abort mid-WAIT, then i_rst mid-search -> o_finish one pulse with o_sha=0; reset clears all outputs.
REQ-030 KILL_BUDGET_EN, NODE_BUDGET=4, oracle never resolves -> finish after 4th accepted query, o_timeout=1.

Source files
------------

// File: rtl/gobang_pkg.sv
// -----------------------------------------------------------------------------
// gobang_pkg
// Shared types and constants for the gomoku kill (VCF/VCT style) search engine.
//   board_t  : 225 cells x 2-bit cell code, cell i at board[i]
//   EMPTY/BLACK/WHITE : cell codes
//   NO_MOVE  : "no move" marker / "search from first candidate"
//   state_t  : search controller states
// -----------------------------------------------------------------------------
package gobang_pkg;

   localparam int         CELLS   = 225;
   localparam logic [7:0] NO_MOVE = 8'hFF;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] BLACK = 2'b01;
   localparam logic [1:0] WHITE = 2'b10;

   typedef logic [CELLS-1:0][1:0] board_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUERY,
      S_WAIT,
      S_DESCEND,
      S_ASCEND,
      S_DONE
   } state_t;

   // BLACK <-> WHITE by swapping the two code bits
   function automatic logic [1:0] opp_side(input logic [1:0] s);
      return {s[0], s[1]};
   endfunction

endpackage

// File: rtl/kill_stack.sv
// -----------------------------------------------------------------------------
// kill_stack
// LIFO of moves played along the current search path (one entry per level).
// Implemented as a shift register so the top is always entry 0.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (stack empty)
//   i_clr        : synchronous clear (new search)
//   i_push       : push i_data (ignored when full)
//   i_pop        : pop top entry (ignored when empty)
//   o_top        : current top, all-ones when empty
// -----------------------------------------------------------------------------
module kill_stack #(
   parameter int DEPTH = 9,
   parameter int W     = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_top
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    empty, full;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign o_top = empty ? '1 : mem_q[0];

   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      // clear only resets the count; stale contents are unreachable
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_push && !full) begin
         mem_d = {mem_q[DEPTH-2:0], i_data};
         cnt_d = cnt_q + 1'b1;
      end else if (i_pop && !empty) begin
         mem_d = {{W{1'b1}}, mem_q[DEPTH-1:1]};
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mem_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/kill_search_engine.sv
// -----------------------------------------------------------------------------
// kill_search_engine
// Depth-limited AND/OR forced-win search. Even levels are attacker (OR),
// odd levels defender (AND). Candidate generation and immediate-win detection
// are delegated to an external oracle via a query/response handshake.
// Optional build macro: KILL_BUDGET_EN -- caps accepted queries per search at
// NODE_BUDGET and reports o_timeout; without it o_timeout is tied low.
// Ports:
//   i_clk, i_rst               : clock, asynchronous active-high reset
//   i_start/i_abort            : begin search (IDLE only) / terminate search
//   i_depth, i_side, i_board   : level limit, attacker code, root position
//   o_q_valid/i_q_ready        : oracle query handshake
//   o_q_board/o_q_level/o_q_after : query contents
//   i_r_valid/i_r_found/i_r_move/i_r_win : oracle response
//   o_busy, o_finish           : running / one-cycle completion pulse
//   o_sha, o_first_move, o_timeout : result, held until next start
// -----------------------------------------------------------------------------
module kill_search_engine
   import gobang_pkg::*;
#(
   parameter int MAX_DEPTH   = 9,
   parameter int MOVE_W      = 8,
   parameter int NODE_BUDGET = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [4:0]        i_depth,
   input  logic [1:0]        i_side,
   input  board_t            i_board,
   output logic              o_q_valid,
   input  logic              i_q_ready,
   output board_t            o_q_board,
   output logic [4:0]        o_q_level,
   output logic [MOVE_W-1:0] o_q_after,
   input  logic              i_r_valid,
   input  logic              i_r_found,
   input  logic [MOVE_W-1:0] i_r_move,
   input  logic              i_r_win,
   output logic              o_busy,
   output logic              o_finish,
   output logic              o_sha,
   output logic [MOVE_W-1:0] o_first_move,
   output logic              o_timeout
);

   localparam logic [MOVE_W-1:0] NOMV    = MOVE_W'(NO_MOVE);
   localparam logic [4:0]        LIM_MAX = 5'(MAX_DEPTH - 1);

   state_t            state_q, state_d;
   board_t            board_q, board_d;
   logic [4:0]        level_q, level_d;
   logic [4:0]        lim_q, lim_d;
   logic [MOVE_W-1:0] after_q, after_d;
   logic [MOVE_W-1:0] mv_q, mv_d;        // candidate awaiting DESCEND
   logic [MOVE_W-1:0] first_q, first_d;
   logic [1:0]        side_q, side_d;
   logic              res_q, res_d;      // child result carried into ASCEND
   logic              sha_q, sha_d;

   logic              stk_push, stk_pop, stk_clr;
   logic [MOVE_W-1:0] stk_top;

   logic              atk, cand_ok;
   // resolution request: node at level rlvl decided with result rres
   logic              rv, rres;
   logic [4:0]        rlvl;
   logic [MOVE_W-1:0] rmv;

`ifdef KILL_BUDGET_EN
   localparam int CNT_W = $clog2(NODE_BUDGET + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tout_q, tout_d;
`endif

   kill_stack #(
      .DEPTH (MAX_DEPTH),
      .W     (MOVE_W)
   ) u_stack (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (stk_clr),
      .i_push (stk_push),
      .i_pop  (stk_pop),
      .i_data (mv_q),
      .o_top  (stk_top)
   );

   assign atk     = ~level_q[0];
   // off-board or occupied candidates count as "nothing found"
   assign cand_ok = i_r_found && (int'(i_r_move) < CELLS) && (board_q[i_r_move] == EMPTY);

   // ---------------- state register ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- next-state / datapath ----------------
   always_comb begin
      state_d  = state_q;
      board_d  = board_q;
      level_d  = level_q;
      lim_d    = lim_q;
      after_d  = after_q;
      mv_d     = mv_q;
      first_d  = first_q;
      side_d   = side_q;
      res_d    = res_q;
      sha_d    = sha_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      stk_clr  = 1'b0;
      rv       = 1'b0;
      rres     = 1'b0;
      rlvl     = level_q;
      rmv      = NOMV;
`ifdef KILL_BUDGET_EN
      cnt_d    = cnt_q;
      tout_d   = tout_q;
`endif

      case (state_q)
         S_IDLE: begin
            // start wins over a simultaneous abort (abort is ignored in IDLE)
            if (i_start) begin
               state_d = S_QUERY;
               board_d = i_board;
               level_d = '0;
               after_d = NOMV;
               lim_d   = (int'(i_depth) >= MAX_DEPTH) ? LIM_MAX : i_depth;
               side_d  = i_side;
               sha_d   = 1'b0;
               first_d = NOMV;
               stk_clr = 1'b1;
`ifdef KILL_BUDGET_EN
               cnt_d   = '0;
               tout_d  = 1'b0;
`endif
            end
         end

         S_DONE: state_d = S_IDLE;

         default: begin
            if (i_abort) begin
               state_d = S_DONE;
               sha_d   = 1'b0;
               first_d = NOMV;
            end else begin
               case (state_q)
                  S_QUERY: begin
                     if (i_q_ready) begin
`ifdef KILL_BUDGET_EN
                        if (cnt_q == CNT_W'(NODE_BUDGET - 1)) begin
                           state_d = S_DONE;
                           sha_d   = 1'b0;
                           first_d = NOMV;
                           tout_d  = 1'b1;
                        end else begin
                           cnt_d   = cnt_q + 1'b1;
                           state_d = S_WAIT;
                        end
`else
                        state_d = S_WAIT;
`endif
                     end
                  end

                  S_WAIT: begin
                     if (i_r_valid) begin
                        if (!cand_ok) begin
                           rv   = 1'b1;
                           rres = ~atk;
                        end else if (i_r_win) begin
                           rv   = 1'b1;
                           rres = atk;
                           rmv  = i_r_move;
                        end else if (level_q == lim_q) begin
                           // no room to go deeper: attacker tries next candidate
                           if (atk) begin
                              after_d = i_r_move;
                              state_d = S_QUERY;
                           end else begin
                              rv   = 1'b1;
                              rres = 1'b0;
                           end
                        end else begin
                           mv_d    = i_r_move;
                           state_d = S_DESCEND;
                        end
                     end
                  end

                  S_DESCEND: begin
                     board_d[mv_q] = atk ? side_q : opp_side(side_q);
                     stk_push      = 1'b1;
                     level_d       = level_q + 5'd1;
                     after_d       = NOMV;
                     state_d       = S_QUERY;
                  end

                  S_ASCEND: begin
                     // undo the parent's move, then apply the child result there
                     board_d[stk_top] = EMPTY;
                     stk_pop          = 1'b1;
                     level_d          = level_q - 5'd1;
                     // parent is attacker when the child level is odd; a
                     // result equal to "parent is attacker" decides the parent
                     if (res_q == level_q[0]) begin
                        rv   = 1'b1;
                        rres = res_q;
                        rlvl = level_q - 5'd1;
                        rmv  = stk_top;
                     end else begin
                        after_d = stk_top;
                        state_d = S_QUERY;
                     end
                  end

                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase

      if (rv) begin
         if (rlvl == '0) begin
            state_d = S_DONE;
            sha_d   = rres;
            first_d = rres ? rmv : NOMV;
         end else begin
            state_d = S_ASCEND;
            res_d   = rres;
            level_d = rlvl;
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         board_q <= '0;
         level_q <= '0;
         lim_q   <= '0;
         after_q <= NOMV;
         mv_q    <= NOMV;
         first_q <= NOMV;
         side_q  <= BLACK;
         res_q   <= 1'b0;
         sha_q   <= 1'b0;
      end else begin
         board_q <= board_d;
         level_q <= level_d;
         lim_q   <= lim_d;
         after_q <= after_d;
         mv_q    <= mv_d;
         first_q <= first_d;
         side_q  <= side_d;
         res_q   <= res_d;
         sha_q   <= sha_d;
      end
   end

`ifdef KILL_BUDGET_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q  <= '0;
         tout_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tout_q <= tout_d;
      end
   end
   assign o_timeout = tout_q;
`else
   assign o_timeout = 1'b0;
`endif

   // ---------------- outputs ----------------
   always_comb begin
      o_q_valid = (state_q == S_QUERY);
      o_busy    = (state_q == S_QUERY) || (state_q == S_WAIT) ||
                  (state_q == S_DESCEND) || (state_q == S_ASCEND);
      o_finish  = (state_q == S_DONE);
   end

   assign o_q_board    = board_q;
   assign o_q_level    = level_q;
   assign o_q_after    = after_q;
   assign o_sha        = sha_q;
   assign o_first_move = first_q;

endmodule

// File: tb/tb_kill_search_engine.sv
module tb_kill_search_engine;
   import gobang_pkg::*;

   typedef struct {
      bit [4:0] lvl;    // expected query level
      bit [7:0] after;  // expected query after
      bit [7:0] cm;     // cell to inspect on the query board (255 = none)
      bit [1:0] cv;     // expected code in that cell
      bit       found;
      bit [7:0] mv;
      bit       win;
      bit       nores;  // accept the query but never answer
   } step_t;

   typedef struct {
      bit       sha;
      bit [7:0] first;
      bit       tout;
   } res_t;

   logic       clk = 0, rst = 1, start = 0, abort = 0;
   logic [4:0] depth = 0;
   logic [1:0] side = BLACK;
   board_t     board = '0;
   logic       q_ready = 0, r_valid = 0, r_found = 0, r_win = 0;
   logic [7:0] r_move = 0;
   logic       q_valid, busy, finish, sha, tout;
   board_t     q_board;
   logic [4:0] q_level;
   logic [7:0] q_after, first;

   int     checks = 0, errors = 0;
   step_t  exp_q[$];
   res_t   exp_r[$];
   board_t root, alt;

   always #5 clk = ~clk;

   kill_search_engine dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .i_depth(depth), .i_side(side), .i_board(board),
      .o_q_valid(q_valid), .i_q_ready(q_ready), .o_q_board(q_board),
      .o_q_level(q_level), .o_q_after(q_after),
      .i_r_valid(r_valid), .i_r_found(r_found), .i_r_move(r_move), .i_r_win(r_win),
      .o_busy(busy), .o_finish(finish), .o_sha(sha), .o_first_move(first),
      .o_timeout(tout));

`ifdef KILL_BUDGET_EN
   logic       b_start = 0, b_ready = 1, b_rv = 0;
   logic       b_q_valid, b_busy, b_finish, b_sha, b_tout;
   board_t     b_q_board;
   logic [4:0] b_q_level;
   logic [7:0] b_q_after, b_first;
   kill_search_engine #(.NODE_BUDGET(4)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_abort(1'b0),
      .i_depth(5'd0), .i_side(BLACK), .i_board(root),
      .o_q_valid(b_q_valid), .i_q_ready(b_ready), .o_q_board(b_q_board),
      .o_q_level(b_q_level), .o_q_after(b_q_after),
      .i_r_valid(b_rv), .i_r_found(1'b1), .i_r_move(8'd5), .i_r_win(1'b0),
      .o_busy(b_busy), .o_finish(b_finish), .o_sha(b_sha), .o_first_move(b_first),
      .o_timeout(b_tout));
`endif

   function automatic step_t st(input int lvl, input int after, input int cm, input int cv,
                                input bit f, input int mv, input bit w, input bit nr);
      step_t s;
      s.lvl = 5'(lvl); s.after = 8'(after); s.cm = 8'(cm); s.cv = 2'(cv);
      s.found = f; s.mv = 8'(mv); s.win = w; s.nores = nr;
      return s;
   endfunction

   function automatic res_t rs(input bit s, input int f);
      res_t r;
      r.sha = s; r.first = 8'(f); r.tout = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      step_t s;
      res_t  r;
      if (!rst && q_valid && q_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL query_unexpected: got level=%0d after=%0d", q_level, q_after);
         end else begin
            s = exp_q.pop_front();
            if (q_level !== s.lvl || q_after !== s.after) begin
               errors++;
               $display("FAIL query: got level=%0d after=%0d expected level=%0d after=%0d",
                        q_level, q_after, s.lvl, s.after);
            end
            if (s.cm != 8'hFF) begin
               checks++;
               if (q_board[s.cm] !== s.cv) begin
                  errors++;
                  $display("FAIL query_board cell %0d: got %0d expected %0d", s.cm, q_board[s.cm], s.cv);
               end
            end
         end
      end
      if (!rst && finish) begin
         checks++;
         if (exp_r.size() == 0) begin
            errors++;
            $display("FAIL finish_unexpected: got sha=%0d first=%0d", sha, first);
         end else begin
            r = exp_r.pop_front();
            if (sha !== r.sha || first !== r.first || tout !== r.tout || busy !== 1'b0) begin
               errors++;
               $display("FAIL result: got sha=%0d first=%0d tout=%0d busy=%0d expected sha=%0d first=%0d tout=%0d busy=0",
                        sha, first, tout, busy, r.sha, r.first, r.tout);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic begin_search(input int d, input logic [1:0] sd, input res_t e, input bit with_abort);
      exp_r.push_back(e);
      board = root; depth = 5'(d); side = sd;
      start = 1; abort = with_abort;
      @(posedge clk); #1;
      start = 0; abort = 0;
   endtask

   task automatic serve(input step_t s);
      int n;
      exp_q.push_back(s);
      q_ready = 1;
      n = 0;
      while (!q_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (!q_valid) begin
         checks++; errors++;
         $display("FAIL query_timeout: got no query, expected level=%0d after=%0d", s.lvl, s.after);
         void'(exp_q.pop_back());
         q_ready = 0;
         return;
      end
      @(posedge clk); #1;
      q_ready = 0;
      if (!s.nores) begin
         r_valid = 1; r_found = s.found; r_move = s.mv; r_win = s.win;
         @(posedge clk); #1;
         r_valid = 0; r_found = 0; r_win = 0;
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (exp_r.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      if (exp_r.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s_finish_timeout: got no finish, expected one", name);
         exp_r.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_busy"},    busy,    0);
      chk({name, "_q_valid"}, q_valid, 0);
      chk({name, "_finish"},  finish,  0);
      chk({name, "_sha"},     sha,     0);
      chk({name, "_first"},   first,   255);
      chk({name, "_timeout"}, tout,    0);
      chk({name, "_board"},   int'(q_board == '0), 1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int n;
      root = '0;
      root[0] = BLACK; root[1] = WHITE; root[224] = WHITE;
      alt = '0;
      alt[77] = BLACK;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 0;
      @(posedge clk); #1;

      // immediate root win; start together with abort (start wins)
      begin_search(4, BLACK, rs(1, 112), 1'b1);
      chk("start_busy", busy, 1);
      serve(st(0, 255, 1, WHITE, 1, 112, 1, 0));
      wait_done("root_win");
      repeat (3) @(posedge clk);
      #1;
      chk("hold_sha", sha, 1);
      chk("hold_first", first, 112);

      // no candidate at the root
      begin_search(4, BLACK, rs(0, 255), 1'b0);
      serve(st(0, 255, 255, 0, 0, 0, 0, 0));
      wait_done("root_none");

      // occupied and off-board winning candidates are treated as not found
      begin_search(4, BLACK, rs(0, 255), 1'b0);
      serve(st(0, 255, 255, 0, 1, 0, 1, 0));
      wait_done("occupied");
      begin_search(4, BLACK, rs(0, 255), 1'b0);
      serve(st(0, 255, 255, 0, 1, 230, 1, 0));
      wait_done("offboard");

      // depth 2: root move 40 refuted, root move 41 forces a win
      begin_search(2, BLACK, rs(1, 41), 1'b0);
      serve(st(0, 255, 255, 0, 1, 40, 0, 0));
      serve(st(1, 255, 40,  BLACK, 1, 50, 1, 0));
      serve(st(0, 40,  40,  EMPTY, 1, 41, 0, 0));
      serve(st(1, 255, 41,  BLACK, 1, 51, 0, 0));
      serve(st(2, 255, 51,  WHITE, 1, 70, 1, 0));
      serve(st(1, 51,  51,  EMPTY, 0, 0, 0, 0));
      wait_done("depth2");
      chk("depth2_board_restored", int'(q_board == root), 1);

      // depth 0: attacker at the limit re-queries after a non-winning move
      begin_search(0, WHITE, rs(1, 20), 1'b0);
      serve(st(0, 255, 255, 0, 1, 10, 0, 0));
      serve(st(0, 10,  255, 0, 1, 20, 1, 0));
      wait_done("depth0");

      // depth 1: defender at the limit with a non-winning reply fails
      begin_search(1, BLACK, rs(0, 255), 1'b0);
      serve(st(0, 255, 255, 0, 1, 30, 0, 0));
      serve(st(1, 255, 30,  BLACK, 1, 31, 0, 0));
      serve(st(0, 30,  30,  EMPTY, 0, 0, 0, 0));
      wait_done("depth1");

      // query held while ready is low; stray response and busy start ignored
      begin_search(4, BLACK, rs(0, 255), 1'b0);
      n = 0;
      while (!q_valid && n < 20) begin @(posedge clk); #1; n++; end
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", q_valid, 1);
         chk("stall_level", q_level, 0);
         chk("stall_after", q_after, 255);
         chk("stall_board", int'(q_board == root), 1);
         if (c == 1) begin board = alt; start = 1; end
         if (c == 2) begin start = 0; r_valid = 1; r_found = 1; r_move = 112; r_win = 1; end
         if (c == 3) begin r_valid = 0; r_found = 0; r_win = 0; end
         @(posedge clk); #1;
      end
      serve(st(0, 255, 1, WHITE, 0, 0, 0, 0));
      wait_done("stall");

      // depth 20 clips to 8; then abort while waiting for a response
      begin_search(20, BLACK, rs(0, 255), 1'b0);
      serve(st(0, 255, 255, 0, 1, 100, 0, 0));
      for (int l = 1; l < 9; l++)
         serve(st(l, 255, 99 + l, (l % 2 == 1) ? BLACK : WHITE, 1, (l == 8) ? 150 : 100 + l, 0, 0));
      serve(st(8, 150, 255, 0, 0, 0, 0, 1));
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      r_valid = 1; r_found = 1; r_move = 9; r_win = 1;
      @(posedge clk); #1;
      r_valid = 0; r_found = 0; r_win = 0;
      wait_done("abort");

      // reset in the middle of a search
      board = root; depth = 5'd2; side = BLACK; start = 1;
      @(posedge clk); #1;
      start = 0;
      serve(st(0, 255, 255, 0, 1, 45, 0, 0));
      serve(st(1, 255, 45, BLACK, 0, 0, 0, 1));
      chk("pre_reset_busy", busy, 1);
      rst = 1;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      // recovery after reset
      begin_search(2, BLACK, rs(1, 60), 1'b0);
      serve(st(0, 255, 45,  EMPTY, 1, 60, 0, 0));
      serve(st(1, 255, 60,  BLACK, 0, 0, 0, 0));
      wait_done("recover");
      chk("recover_board_restored", int'(q_board == root), 1);

`ifdef KILL_BUDGET_EN
      begin
         int nhs, m;
         b_start = 1;
         @(posedge clk); #1;
         b_start = 0;
         nhs = 0; m = 0;
         while (!b_finish && m < 100) begin
            if (b_q_valid) begin
               nhs++;
               @(posedge clk); #1;
               if (!b_finish) begin
                  b_rv = 1;
                  @(posedge clk); #1;
                  b_rv = 0;
               end
            end else begin
               @(posedge clk); #1;
            end
            m++;
         end
         chk("budget_finish", b_finish, 1);
         chk("budget_queries", nhs, 4);
         chk("budget_timeout", b_tout, 1);
         chk("budget_sha", b_sha, 0);
         chk("budget_first", b_first, 255);
      end
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("leftover_queries", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
